// File: rtl/scroll_tile_gen.sv
// scroll_tile_gen: two-colour tiled pattern generator with sub-pixel scrolling and periodic
// colour swap. Sits in the pattern bank; rgb_o feeds the top-level pattern mux.
//
// Ports:
//   clk_i            pixel clock
//   rst_ni           asynchronous active-low reset (clears rgb_o immediately)
//   pattern_enable_i block selected; gates all state updates (pixel path always runs)
//   x_i, y_i         current pixel column / row
//   active_i         visible-area flag
//   next_frame_i     one-cycle frame-boundary pulse
//   step_size_i      unsigned fixed-point step per frame, {int, frac}
//   mode_i           00 horizontal, 01 vertical, 10 diagonal, 11 frozen
//   reverse_i        1 = subtract step instead of add
//   swap_enable_i    enables periodic colour swap
//   rgb_o            registered pixel colour, 1 clock after x_i/y_i/active_i
module scroll_tile_gen #(
  parameter int unsigned COORD_W      = 10,
  parameter int unsigned OFFSET_W     = 8,
  parameter int unsigned FRAC_W       = 2,
  parameter int unsigned STEP_W       = 3,
  parameter int unsigned OFFSET_SCALE = 1,
  parameter int unsigned TILE_LOG2    = 5,
  parameter int unsigned SWAP_PERIOD  = 60,
  parameter logic [5:0]  COLOR_A      = 6'b100100,
  parameter logic [5:0]  COLOR_B      = 6'b000000
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               pattern_enable_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic               active_i,
  input  logic               next_frame_i,
  input  logic [STEP_W-1:0]  step_size_i,
  input  logic [1:0]         mode_i,
  input  logic               reverse_i,
  input  logic               swap_enable_i,
  output logic [5:0]         rgb_o
);

  localparam int unsigned IntW = STEP_W - FRAC_W;
  localparam int unsigned CntW = (SWAP_PERIOD > 1) ? $clog2(SWAP_PERIOD) : 1;

  logic [OFFSET_W-1:0] x_off_q, x_off_d, y_off_q, y_off_d;
  logic [FRAC_W-1:0]   x_frac_q, x_frac_d, y_frac_q, y_frac_d;
  logic [CntW-1:0]     swap_cnt_q, swap_cnt_d;
  logic                swap_flag_q, swap_flag_d;
  logic [5:0]          rgb_q, rgb_d;

  logic [IntW-1:0]     step_int;
  logic [FRAC_W-1:0]   step_frac;
  logic                update;

  assign step_int  = step_size_i[STEP_W-1:FRAC_W];
  assign step_frac = step_size_i[FRAC_W-1:0];
  assign update    = pattern_enable_i & next_frame_i;

  // One axis step: the fraction's carry (or borrow) ripples into the integer offset.
  function automatic logic [OFFSET_W+FRAC_W-1:0] axis_step(
    input logic [OFFSET_W-1:0] off,
    input logic [FRAC_W-1:0]   frac,
    input logic                rev,
    input logic [IntW-1:0]     sint,
    input logic [FRAC_W-1:0]   sfrac
  );
    logic [FRAC_W:0]     f;
    logic [OFFSET_W-1:0] o;
    if (!rev) begin
      f = {1'b0, frac} + {1'b0, sfrac};
      o = off + OFFSET_W'(sint) + OFFSET_W'(f[FRAC_W]);
    end else begin
      f = {1'b0, frac} - {1'b0, sfrac};
      o = off - OFFSET_W'(sint) - OFFSET_W'(f[FRAC_W]);
    end
    return {o, f[FRAC_W-1:0]};
  endfunction

  logic [OFFSET_W+FRAC_W-1:0] x_next, y_next;
  assign x_next = axis_step(x_off_q, x_frac_q, reverse_i, step_int, step_frac);
  assign y_next = axis_step(y_off_q, y_frac_q, reverse_i, step_int, step_frac);

  always_comb begin
    x_off_d     = x_off_q;
    x_frac_d    = x_frac_q;
    y_off_d     = y_off_q;
    y_frac_d    = y_frac_q;
    swap_cnt_d  = swap_cnt_q;
    swap_flag_d = swap_flag_q;

    if (update) begin
      case (mode_i)
        2'b00: {x_off_d, x_frac_d} = x_next;
        2'b01: {y_off_d, y_frac_d} = y_next;
        2'b10: begin
          {x_off_d, x_frac_d} = x_next;
          {y_off_d, y_frac_d} = y_next;
        end
        default: ;
      endcase
    end

    if (pattern_enable_i) begin
      if (!swap_enable_i) begin
        swap_cnt_d = '0;
      end else if (next_frame_i) begin
        if (swap_cnt_q == CntW'(SWAP_PERIOD - 1)) begin
          swap_cnt_d  = '0;
          swap_flag_d = ~swap_flag_q;
        end else begin
          swap_cnt_d = swap_cnt_q + 1'b1;
        end
      end
    end
  end

  // Pixel path: uses the pre-update offsets in the cycle of an update event.
  logic [COORD_W-1:0] sx, sy;
  logic               tile;
  logic               unused_pix;

  assign sx   = x_i + (COORD_W'(x_off_q) << OFFSET_SCALE);
  assign sy   = y_i + (COORD_W'(y_off_q) << OFFSET_SCALE);
  assign tile = sx[TILE_LOG2] ^ sy[TILE_LOG2] ^ swap_flag_q;
  // Only the tile-select bit of each sum matters.
  assign unused_pix = ^{sx, sy};

  always_comb begin
    rgb_d = 6'b000000;
    if (active_i) begin
      rgb_d = tile ? COLOR_A : COLOR_B;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_off_q     <= '0;
      x_frac_q    <= '0;
      y_off_q     <= '0;
      y_frac_q    <= '0;
      swap_cnt_q  <= '0;
      swap_flag_q <= 1'b0;
      rgb_q       <= 6'b000000;
    end else begin
      x_off_q     <= x_off_d;
      x_frac_q    <= x_frac_d;
      y_off_q     <= y_off_d;
      y_frac_q    <= y_frac_d;
      swap_cnt_q  <= swap_cnt_d;
      swap_flag_q <= swap_flag_d;
      rgb_q       <= rgb_d;
    end
  end

  assign rgb_o = rgb_q;

endmodule

// File: tb/tb_scroll_tile_gen.sv
// Bench for scroll_tile_gen: directed scenarios plus a randomized phase, checked against a
// model that tracks each axis as a single position in fractional-pixel units.
module tb_scroll_tile_gen;

  localparam int COORD_W      = 10;
  localparam int OFFSET_W     = 8;
  localparam int FRAC_W       = 2;
  localparam int STEP_W       = 3;
  localparam int OFFSET_SCALE = 1;
  localparam int TILE_LOG2    = 5;
  localparam int SWAP_PERIOD  = 4;
  localparam logic [5:0] COLOR_A = 6'b100100;
  localparam logic [5:0] COLOR_B = 6'b000000;
  localparam int POS_MOD  = 1 << (OFFSET_W + FRAC_W);
  localparam int FRAC_DIV = 1 << FRAC_W;

  logic               clk;
  logic               rst_n;
  logic               pattern_enable;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               active;
  logic               next_frame;
  logic [STEP_W-1:0]  step_size;
  logic [1:0]         mode;
  logic               reverse;
  logic               swap_enable;
  logic [5:0]         rgb;

  scroll_tile_gen #(
    .SWAP_PERIOD (SWAP_PERIOD)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .pattern_enable_i (pattern_enable),
    .x_i              (x),
    .y_i              (y),
    .active_i         (active),
    .next_frame_i     (next_frame),
    .step_size_i      (step_size),
    .mode_i           (mode),
    .reverse_i        (reverse),
    .swap_enable_i    (swap_enable),
    .rgb_o            (rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: axis position in 1/2^FRAC_W pixel units, swap frame count and flag.
  int m_px, m_py, m_cnt, m_flag;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int wrap_pos(input int p);
    return ((p % POS_MOD) + POS_MOD) % POS_MOD;
  endfunction

  function automatic logic [5:0] model_rgb(input int px, input int py, input logic act);
    int sx, sy, t;
    if (!act) return 6'b000000;
    sx = (px + (m_px / FRAC_DIV) * (1 << OFFSET_SCALE)) % (1 << COORD_W);
    sy = (py + (m_py / FRAC_DIV) * (1 << OFFSET_SCALE)) % (1 << COORD_W);
    t  = ((sx / (1 << TILE_LOG2)) + (sy / (1 << TILE_LOG2)) + m_flag) % 2;
    return (t != 0) ? COLOR_A : COLOR_B;
  endfunction

  // Advance the model by one clock given the inputs currently driven.
  task automatic model_clock();
    int d;
    if (pattern_enable && next_frame) begin
      d = reverse ? -int'(step_size) : int'(step_size);
      if (mode == 2'd0 || mode == 2'd2) m_px = wrap_pos(m_px + d);
      if (mode == 2'd1 || mode == 2'd2) m_py = wrap_pos(m_py + d);
    end
    if (pattern_enable) begin
      if (!swap_enable) begin
        m_cnt = 0;
      end else if (next_frame) begin
        m_cnt++;
        if (m_cnt == SWAP_PERIOD) begin
          m_cnt  = 0;
          m_flag = 1 - m_flag;
        end
      end
    end
  endtask

  // Drive one pixel (optionally with a frame pulse) and check rgb one clock later.
  task automatic pix(input int px, input int py, input logic act, input logic nf,
                     input string tag);
    logic [5:0] exp;
    x          = COORD_W'(px);
    y          = COORD_W'(py);
    active     = act;
    next_frame = nf;
    exp        = model_rgb(px, py, act);
    model_clock();
    @(posedge clk);
    @(negedge clk);
    next_frame = 1'b0;
    check_val(tag, 32'(rgb), 32'(exp));
  endtask

  task automatic frame(input string tag);
    pix(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b1, 1'b1, tag);
  endtask

  task automatic check_state(input string tag);
    check_val({tag, ".x_off"},  32'(dut.x_off_q),  32'(m_px / FRAC_DIV));
    check_val({tag, ".x_frac"}, 32'(dut.x_frac_q), 32'(m_px % FRAC_DIV));
    check_val({tag, ".y_off"},  32'(dut.y_off_q),  32'(m_py / FRAC_DIV));
    check_val({tag, ".y_frac"}, 32'(dut.y_frac_q), 32'(m_py % FRAC_DIV));
    check_val({tag, ".flag"},   32'(dut.swap_flag_q), 32'(m_flag));
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rgb", 32'(rgb), 32'd0);
    m_px = 0; m_py = 0; m_cnt = 0; m_flag = 0;
    check_state("async_reset");
    check_val("async_reset.cnt", 32'(dut.swap_cnt_q), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [5:0] e;
    int         tries;
    rst_n = 1'b0; pattern_enable = 1'b1; x = '0; y = '0; active = 1'b0; next_frame = 1'b0;
    step_size = '0; mode = 2'd0; reverse = 1'b0; swap_enable = 1'b0;
    m_px = 0; m_py = 0; m_cnt = 0; m_flag = 0;
    repeat (2) @(negedge clk);
    check_val("reset_rgb", 32'(rgb), 32'd0);
    check_state("reset");
    rst_n = 1'b1;

    // Forward horizontal step, then the two reference pixels.
    mode = 2'd0; reverse = 1'b0; step_size = 3'b100;
    frame("fwd_frame");
    check_state("fwd");
    check_val("fwd.x_off_lit", 32'(dut.x_off_q), 32'd1);
    pix(62, 0, 1'b1, 1'b0, "fwd_px62");
    check_val("fwd_px62_lit", 32'(rgb), 32'(COLOR_B));
    pix(30, 0, 1'b1, 1'b0, "fwd_px30");
    check_val("fwd_px30_lit", 32'(rgb), 32'(COLOR_A));

    // Fractional accumulation.
    do_reset();
    step_size = 3'b001;
    repeat (3) frame("frac1_frame");
    check_state("frac1_3");
    frame("frac1_frame");
    check_state("frac1_4");
    do_reset();
    step_size = 3'b111;
    repeat (2) frame("frac7_frame");
    check_state("frac7_2");

    // Reverse and wrap.
    do_reset();
    reverse = 1'b1; step_size = 3'b100;
    frame("rev_frame");
    check_state("rev_wrap");
    reverse = 1'b0;
    frame("fwd_frame");
    check_state("fwd_wrap");
    reverse = 1'b1; step_size = 3'b001;
    frame("rev_frame");
    check_state("rev_frac_wrap");

    // Mode coverage.
    do_reset();
    reverse = 1'b0; step_size = 3'b100; mode = 2'd1;
    repeat (2) frame("vert_frame");
    check_state("vert");
    mode = 2'd2;
    frame("diag_frame");
    check_state("diag");
    mode = 2'd3;
    repeat (5) frame("frozen_frame");
    check_state("frozen");
    mode = 2'd2; step_size = 3'b000;
    frame("zero_step_frame");
    check_state("zero_step");

    // Colour swap with a frozen pattern at pixel (0,0).
    do_reset();
    mode = 2'd3; swap_enable = 1'b1;
    repeat (4) pix(0, 0, 1'b1, 1'b1, "swap_pre");
    pix(0, 0, 1'b1, 1'b0, "swap_post");
    check_state("swap");
    pix(0, 0, 1'b1, 1'b1, "swap_cnt_up");
    swap_enable = 1'b0;
    pix(0, 0, 1'b1, 1'b0, "swap_drop");
    check_val("swap_drop.cnt", 32'(dut.swap_cnt_q), 32'd0);
    check_state("swap_drop");

    // Gating: frame pulses with the block deselected change nothing.
    pattern_enable = 1'b0; swap_enable = 1'b1; mode = 2'd2; step_size = 3'b111;
    repeat (3) frame("gated_frame");
    check_state("gated");
    pattern_enable = 1'b1;
    repeat (3) frame("ungated_frame");
    check_state("ungated");

    // Put a COLOR_A pixel on the output, then reset between edges.
    tries = 0;
    do begin
      x = COORD_W'($urandom_range(0, 1023));
      y = COORD_W'($urandom_range(0, 1023));
      tries++;
    end while (model_rgb(int'(x), int'(y), 1'b1) != COLOR_A && tries < 1000);
    pix(int'(x), int'(y), 1'b1, 1'b0, "pre_async");
    do_reset();

    // Inactive pixels are black regardless of tile.
    for (int i = 0; i < 4; i++) begin
      pix(32 * i, 0, 1'b0, 1'b0, "inactive");
    end

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      pattern_enable = ($urandom_range(0, 7) != 0);
      mode           = 2'($urandom_range(0, 3));
      reverse        = 1'($urandom_range(0, 1));
      step_size      = STEP_W'($urandom_range(0, 7));
      swap_enable    = ($urandom_range(0, 5) != 0);
      pix(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), "rand_rgb");
      if (i % 25 == 24) check_state("rand");
      if (i == 200) do_reset();
    end

    e = model_rgb(0, 0, 1'b1);
    pix(0, 0, 1'b1, 1'b0, "final_px");
    check_val("final_px_model", 32'(rgb), 32'(e));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scroll_tile_gen.md
Name: scroll_tile_gen

Overview:
- Parametrised successor to the fixed checkerboard pattern generator.
- Produces a two-colour tiled pattern with configurable tile size and colours.
- Scrolls horizontally, vertically or diagonally, forward or reverse, using a fixed-point step from speed_controller.
- Optionally swaps the two colours every SWAP_PERIOD frames. Sits in the pattern bank; its rgb feeds the top-level pattern mux.

Parameters:
COORD_W, 10, width of x/y pixel coordinates
OFFSET_W, 8, width of each integer scroll offset (wraps mod 2^OFFSET_W)
FRAC_W, 2, fractional bits of step_size and of the subpixel accumulators
STEP_W, 3, total step_size width; integer part = STEP_W-FRAC_W bits (STEP_W > FRAC_W)
OFFSET_SCALE, 1, left shift applied to offsets before adding to coordinates
TILE_LOG2, 5, tile edge = 2^TILE_LOG2 pixels; coordinate bit TILE_LOG2 selects the tile (TILE_LOG2 < COORD_W)
SWAP_PERIOD, 60, frames between colour swaps (>= 1)
COLOR_A, 6'b100100, colour of "set" tiles
COLOR_B, 6'b000000, colour of "clear" tiles

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
pattern_enable  in  1  block selected; gates all state updates
x  in  COORD_W  current pixel column
y  in  COORD_W  current pixel row
active  in  1  visible-area flag
next_frame  in  1  one-cycle frame-boundary pulse
step_size  in  STEP_W  unsigned fixed-point step per frame, {int, frac}
mode  in  2  00 horizontal, 01 vertical, 10 diagonal, 11 frozen
reverse  in  1  1 = subtract step instead of add
swap_enable  in  1  enables periodic colour swap
rgb  out  6  registered pixel colour

Behaviour:
- Reset (rst_n low, asynchronous): x_off, y_off, x_frac, y_frac, swap_cnt and swap_flag go to 0; rgb goes to 6'b000000 immediately, without waiting for a clock edge.
- Update event: pattern_enable && next_frame on a rising edge. No state changes without an update event; all state holds.
- Axis selection per update event:
  - mode=00 updates x_off/x_frac only.
  - mode=01 updates y_off/y_frac only.
  - mode=10 updates both axes with the same step.
  - mode=11 updates neither axis.
  - mode and reverse are sampled in the update cycle. A mode change holds the offsets of axes that stop moving.
- Forward axis update: frac_sum = frac + step[FRAC_W-1:0] over FRAC_W+1 bits. frac <= frac_sum[FRAC_W-1:0]. off <= off + step_int + carry, where carry = frac_sum[FRAC_W].
- Reverse axis update: frac_diff = frac - step[FRAC_W-1:0] with borrow. frac <= low FRAC_W bits. off <= off - step_int - borrow.
- Offset arithmetic is mod 2^OFFSET_W in both directions (255+1 -> 0; 0-1 -> 255 at default width).
- Swap counter:
  - On each update event with swap_enable=1 (any mode, frozen included), swap_cnt increments.
  - When swap_cnt == SWAP_PERIOD-1, swap_cnt <= 0 and swap_flag toggles.
  - swap_enable=0 clears swap_cnt to 0 on the next clock; swap_flag holds its value.
- Pixel path:
  - sx = x + (x_off << OFFSET_SCALE), sy = y + (y_off << OFFSET_SCALE), both truncated to COORD_W.
  - tile = sx[TILE_LOG2] ^ sy[TILE_LOG2] ^ swap_flag.
  - Every clock: rgb <= !active ? 0 : (tile ? COLOR_A : COLOR_B).
- Latency: exactly 1 clock from x/y/active to rgb. The pixel path runs regardless of pattern_enable.
- next_frame in the same cycle as an active pixel: that pixel uses the pre-update offsets; the new offsets apply from the following cycle.
- step_size = 0 with an update event: offsets and fractions are unchanged; the swap counter still advances.
- rst_n deasserted mid-frame: the block resumes from the zero state on the next clock edge. The first update event is the next next_frame pulse.

Test Plan:
- Forward horizontal step: reset, mode=00, reverse=0, step=3'b100, one next_frame. Then x_off=1 and y_off=0. Pixel (62,0,active) -> sx=64, tile=0 -> rgb=6'b000000 one clock later. Pixel (30,0) -> sx=32 -> rgb=6'b100100.
- Fractional accumulation: step=3'b001 -> x_off stays 0 for 3 frames and becomes 1 on the 4th with x_frac=0. Step=3'b111 -> after 2 frames x_off=3, x_frac=2'b10.
- Reverse and wrap: from reset, reverse=1, step=3'b100 -> x_off=255. Then reverse=0, step=3'b100 -> x_off=0. Reverse with step=3'b001 from zero -> x_off=255, x_frac=2'b11.
- Mode coverage: mode=01 step=3'b100 for 2 frames -> x_off=0, y_off=2. Then mode=10 for 1 frame -> x_off=1, y_off=3. Then mode=11 for 5 frames -> offsets unchanged.
- Colour swap (SWAP_PERIOD=4 override): swap_enable=1, pixel (0,0) -> rgb=6'b000000 (COLOR_B) until the 4th next_frame, then rgb=6'b100100 (COLOR_A). Dropping swap_enable keeps swap_flag=1 and clears swap_cnt.
- Async reset and gating: pattern_enable=0 with next_frame pulses -> no state change. Assert rst_n=0 between clock edges -> rgb=0 and all offsets 0 before the next edge. active=0 -> rgb=0 regardless of tile.
